// File: rtl/rvfi_check_sequencer.sv
// One-shot check strobe generator for single-instruction RVFI checkers: fires when
// target_order retires on CHANNEL_IDX inside [MIN_CYCLES, MAX_CYCLES], tracks predecessor.
module rvfi_check_sequencer #(
    parameter int NRET        = 1,
    parameter int CHANNEL_IDX = 0,
    parameter int MIN_CYCLES  = 10,
    parameter int MAX_CYCLES  = 20,
    parameter int CNT_W       = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic                 rvfi_rollback_valid,
    input  logic [63:0]          rvfi_rollback_order,
    input  logic [63:0]          target_order,
    output logic                 check,
    output logic                 pred_ok,
    output logic                 done,
    output logic                 missed,
    output logic                 timeout,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_ARMED   = 3'd1,
        S_DONE    = 3'd2,
        S_MISSED  = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // With no lower bound the window is open from the first cycle out of reset.
    localparam state_t          RESET_STATE = (MIN_CYCLES == 0) ? S_ARMED : S_WAIT;
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] ARM_AT     = CNT_W'(MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_AT    = CNT_W'(MAX_CYCLES);

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic             pred_seen;
    logic             hit;
    logic             pred_now;
    logic             pred_low;
    logic [63:0]      pred_order;

    assign pred_order = target_order - 64'd1;
    assign hit = rvfi_valid[CHANNEL_IDX] &&
                 (rvfi_order[64*CHANNEL_IDX +: 64] == target_order);

    // Only channels below CHANNEL_IDX retire before the target within one cycle.
    always_comb begin
        pred_now = 1'b0;
        pred_low = 1'b0;
        for (int j = 0; j < NRET; j++) begin
            if (rvfi_valid[j] && (rvfi_order[64*j +: 64] == pred_order)) begin
                pred_now = 1'b1;
                if (j < CHANNEL_IDX) pred_low = 1'b1;
            end
        end
        if (target_order == 64'd0) begin
            pred_now = 1'b0;
            pred_low = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        check      = 1'b0;
        pred_ok    = 1'b0;
        case (state)
            S_WAIT: begin
                if (hit)                  state_next = S_MISSED;
                else if (count == ARM_AT) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (hit) begin
                    check      = 1'b1;
                    pred_ok    = pred_seen || pred_low;
                    state_next = S_DONE;
                end else if (count == LAST_AT) begin
                    state_next = S_TIMEOUT;
                end
            end
            default: ;
        endcase
        if (reset) begin
            check   = 1'b0;
            pred_ok = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RESET_STATE;
            count     <= '0;
            pred_seen <= 1'b0;
        end else begin
            state <= state_next;
            count <= (count == CNT_SAT) ? count : count + 1'b1;
            // A retirement in the same cycle as a rollback comes after it, so it wins.
            if (state == S_WAIT || state == S_ARMED) begin
                if (pred_now)
                    pred_seen <= 1'b1;
                else if (rvfi_rollback_valid && (rvfi_rollback_order <= pred_order))
                    pred_seen <= 1'b0;
            end
        end
    end

    assign done      = (state == S_DONE);
    assign missed    = (state == S_MISSED);
    assign timeout   = (state == S_TIMEOUT);
    assign dbg_state = state;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench: drivers push {cycle, pred_ok} per expected check strobe; per-DUT
// monitors pop on every strobe. Status flags are checked at fixed cycles.
module tb_rvfi_check_sequencer;

    logic clock = 1'b0;
    logic reset;
    logic rb_valid;
    logic [63:0] rb_order;
    logic [63:0] target;
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    logic [0:0]   a_valid;
    logic [63:0]  a_order;
    logic a_check, a_pred_ok, a_done, a_missed, a_timeout;
    logic [2:0] a_dbg;
    logic [1:0]   b_valid, c_valid;
    logic [127:0] b_order, c_order;
    logic b_check, b_pred_ok, b_done, b_missed, b_timeout;
    logic c_check, c_pred_ok, c_done, c_missed, c_timeout;
    logic [2:0] b_dbg, c_dbg;

    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];
    logic [8:0] exp_c_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

    rvfi_check_sequencer #(.NRET(1), .CHANNEL_IDX(0)) u_a (
        .clock(clock), .reset(reset), .rvfi_valid(a_valid), .rvfi_order(a_order),
        .rvfi_rollback_valid(rb_valid), .rvfi_rollback_order(rb_order),
        .target_order(target), .check(a_check), .pred_ok(a_pred_ok), .done(a_done),
        .missed(a_missed), .timeout(a_timeout), .dbg_state(a_dbg));

    rvfi_check_sequencer #(.NRET(2), .CHANNEL_IDX(1)) u_b (
        .clock(clock), .reset(reset), .rvfi_valid(b_valid), .rvfi_order(b_order),
        .rvfi_rollback_valid(1'b0), .rvfi_rollback_order(64'd0),
        .target_order(target), .check(b_check), .pred_ok(b_pred_ok), .done(b_done),
        .missed(b_missed), .timeout(b_timeout), .dbg_state(b_dbg));

    rvfi_check_sequencer #(.NRET(2), .CHANNEL_IDX(0)) u_c (
        .clock(clock), .reset(reset), .rvfi_valid(c_valid), .rvfi_order(c_order),
        .rvfi_rollback_valid(1'b0), .rvfi_rollback_order(64'd0),
        .target_order(target), .check(c_check), .pred_ok(c_pred_ok), .done(c_done),
        .missed(c_missed), .timeout(c_timeout), .dbg_state(c_dbg));

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    // Monitors: each strobe must match the head of its queue as {cycle, pred_ok}.
    always @(negedge clock) begin
        if (a_check !== 1'b0) begin
            if (exp_a_q.size() == 0) check_eq("a_unexpected_check", a_check, 0);
            else check_eq("a_check_event", {cyc[7:0], a_pred_ok}, exp_a_q.pop_front());
        end
        if (b_check !== 1'b0) begin
            if (exp_b_q.size() == 0) check_eq("b_unexpected_check", b_check, 0);
            else check_eq("b_check_event", {cyc[7:0], b_pred_ok}, exp_b_q.pop_front());
        end
        if (c_check !== 1'b0) begin
            if (exp_c_q.size() == 0) check_eq("c_unexpected_check", c_check, 0);
            else check_eq("c_check_event", {cyc[7:0], c_pred_ok}, exp_c_q.pop_front());
        end
    end

    task automatic clear_inputs();
        a_valid = '0; a_order = '0;
        b_valid = '0; b_order = '0;
        c_valid = '0; c_order = '0;
        rb_valid = 1'b0; rb_order = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic goto(input int n);
        int k = 0;
        while (cyc != n && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (cyc != n) check_eq("goto_budget", cyc, n);
    endtask

    task automatic drive_a(input logic v, input logic [63:0] ord);
        a_valid = v;
        a_order = ord;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        target = 64'd5;
        clear_inputs();

        // Reset state
        do_reset();
        check_eq("rst_done", a_done, 0);
        check_eq("rst_missed", a_missed, 0);
        check_eq("rst_timeout", a_timeout, 0);
        check_eq("rst_state", a_dbg, 0);

        // Predecessor then target inside the window
        goto(11); drive_a(1, 4);
        goto(12); drive_a(1, 5); exp_a_q.push_back({8'd12, 1'b1});
        goto(13); drive_a(0, 0);
        check_eq("t1_done", a_done, 1);
        goto(14);
        check_eq("t1_done_hold", a_done, 1);
        check_eq("t1_timeout", a_timeout, 0);

        // Early retirement, then a retry inside the window is ignored
        do_reset();
        goto(3); drive_a(1, 5);
        goto(4); drive_a(0, 0);
        check_eq("t2_missed", a_missed, 1);
        goto(12); drive_a(1, 5);
        goto(13); drive_a(0, 0);
        check_eq("t2_missed_hold", a_missed, 1);
        check_eq("t2_not_done", a_done, 0);

        // Retirement one cycle before the window opens
        do_reset();
        goto(9); drive_a(1, 5);
        goto(10); drive_a(0, 0);
        check_eq("min_minus1_missed", a_missed, 1);

        // Timeout and late retirement
        do_reset();
        goto(20);
        check_eq("t3_no_timeout_yet", a_timeout, 0);
        goto(21);
        check_eq("t3_timeout", a_timeout, 1);
        goto(25); drive_a(1, 5);
        goto(26); drive_a(0, 0);
        check_eq("t3_timeout_hold", a_timeout, 1);
        check_eq("t3_not_done", a_done, 0);

        // Window edges are inclusive
        do_reset();
        goto(20); drive_a(1, 5); exp_a_q.push_back({8'd20, 1'b0});
        goto(21); drive_a(0, 0);
        check_eq("max_edge_done", a_done, 1);
        check_eq("max_edge_timeout", a_timeout, 0);
        do_reset();
        goto(10); drive_a(1, 5); exp_a_q.push_back({8'd10, 1'b0});
        goto(11); drive_a(0, 0);
        check_eq("min_edge_done", a_done, 1);

        // Rollback covering the predecessor clears it
        do_reset();
        goto(11); drive_a(1, 4);
        goto(12); drive_a(0, 0); rb_valid = 1'b1; rb_order = 64'd3;
        goto(13); rb_valid = 1'b0; drive_a(1, 5); exp_a_q.push_back({8'd13, 1'b0});
        goto(14); drive_a(0, 0);
        check_eq("t5_done", a_done, 1);

        // Rollback past the predecessor keeps it
        do_reset();
        goto(11); drive_a(1, 4);
        goto(12); drive_a(0, 0); rb_valid = 1'b1; rb_order = 64'd5;
        goto(13); rb_valid = 1'b0; drive_a(1, 5); exp_a_q.push_back({8'd13, 1'b1});
        goto(14); drive_a(0, 0);

        // Re-retirement in the same cycle as a rollback wins
        do_reset();
        goto(11); drive_a(1, 4);
        goto(12); drive_a(1, 4); rb_valid = 1'b1; rb_order = 64'd3;
        goto(13); rb_valid = 1'b0; drive_a(1, 5); exp_a_q.push_back({8'd13, 1'b1});
        goto(14); drive_a(0, 0);

        // Target order 0 has no predecessor; reset clears flags
        do_reset();
        target = 64'd0;
        goto(10); drive_a(1, 0); exp_a_q.push_back({8'd10, 1'b0});
        goto(11); drive_a(0, 0);
        check_eq("t6_done", a_done, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("t6_rst_done", a_done, 0);
        check_eq("t6_rst_missed", a_missed, 0);
        check_eq("t6_rst_timeout", a_timeout, 0);
        target = 64'd5;

        // A hit while reset is high must not strobe; new epoch fires normally
        do_reset();
        goto(15); reset = 1'b1; drive_a(1, 5);
        @(posedge clock); #1 reset = 1'b0; drive_a(0, 0);
        check_eq("midrst_state", a_dbg, 0);
        check_eq("midrst_done", a_done, 0);
        goto(12); drive_a(1, 5); exp_a_q.push_back({8'd12, 1'b0});
        goto(13); drive_a(0, 0);
        check_eq("midrst_epoch_done", a_done, 1);

        // Two channels: predecessor on a lower channel counts, on a higher one does not
        do_reset();
        goto(12);
        b_valid = 2'b11; b_order = {64'd5, 64'd4}; exp_b_q.push_back({8'd12, 1'b1});
        c_valid = 2'b11; c_order = {64'd4, 64'd5}; exp_c_q.push_back({8'd12, 1'b0});
        goto(13);
        b_valid = 2'b00; c_valid = 2'b00;
        check_eq("t4_b_done", b_done, 1);
        check_eq("t4_c_done", c_done, 1);

        goto(16);
        check_eq("a_queue_drained", exp_a_q.size(), 0);
        check_eq("b_queue_drained", exp_b_q.size(), 0);
        check_eq("c_queue_drained", exp_c_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
